// File: rtl/level_pkg.sv
// Shared types and constants for the level generator: cell codes, FSM states, LFSR taps.
package level_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_WALL  = 2'b01,
        CELL_GOAL  = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_GOAL,
        ST_DONE
    } lvl_state_t;

    // Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/level_generator_if.sv
// Map RAM write port: generator presents we/waddr/wdata, RAM grants with wready.
interface level_generator_if #(
    parameter int ADDR_W = 10
);
    import level_pkg::*;

    logic              we;
    logic              wready;
    logic [ADDR_W-1:0] waddr;
    cell_t             wdata;

    modport master (output we, output waddr, output wdata, input wready);
    modport slave  (input we, input waddr, input wdata, output wready);

endinterface

// File: rtl/level_generator_lfsr16.sv
// 16-bit Galois LFSR, advances one step per cycle while i_en is high; exposes its low byte.
// Zero latency on o_value; holds its state when i_en is low.
module lfsr16
    import level_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [7:0] o_value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = i_en ? lfsr_next(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign o_value = lfsr_q[7:0];

endmodule

// File: rtl/level_generator.sv
// Streams a fresh level into the tile RAM: N fill writes, one goal write, then a one-cycle ready pulse.
// Ready arrives N+2 cycles after start at full grant; a withheld grant freezes address, data and LFSR.
module level_generator
    import level_pkg::*;
#(
    parameter int          MAP_W        = 32,
    parameter int          MAP_H        = 24,
    parameter int          RATING_WIDTH = 8,
    parameter int          BASE_DENSITY = 24,
    parameter int          DENSITY_STEP = 4,
    parameter int          MAX_DENSITY  = 96,
    parameter int          SAFE_X0      = 12,
    parameter int          SAFE_W       = 8,
    parameter logic [15:0] SEED         = 16'hACE1
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_regenerate,
    input  logic [RATING_WIDTH-1:0] i_rating,
    output logic                    o_busy,
    output logic                    o_ready,
    level_generator_if.master       wr_if
);

    localparam int AW = $clog2(MAP_W * MAP_H);
    localparam int XW = $clog2(MAP_W);
    localparam int TW = RATING_WIDTH + 9;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MAP_W * MAP_H - 1);
    localparam logic [AW-1:0] ROW_LAST  = AW'((MAP_H - 1) * MAP_W);
    localparam logic [XW:0]   SAFE_LO   = (XW+1)'(SAFE_X0);
    localparam logic [XW:0]   SAFE_HI   = (XW+1)'(SAFE_X0 + SAFE_W);
    localparam logic [TW-1:0] BASE_T    = TW'(BASE_DENSITY);
    localparam logic [TW-1:0] STEP_T    = TW'(DENSITY_STEP);
    localparam logic [TW-1:0] MAX_T     = TW'(MAX_DENSITY);

    lvl_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    thr_q, thr_d;

    logic          lfsr_en;
    logic [7:0]    lfsr_v;
    logic [TW-1:0] thr_wide;
    logic [7:0]    thr_sat;
    logic [XW-1:0] cell_x;
    logic          in_safe;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (lfsr_en),
        .o_value (lfsr_v)
    );

    // Wide enough that the rating product never wraps before the cap is applied
    assign thr_wide = BASE_T + TW'(i_rating) * STEP_T;
    assign thr_sat  = (thr_wide > MAX_T) ? 8'(MAX_DENSITY) : thr_wide[7:0];

    assign cell_x  = cnt_q[XW-1:0];
    assign in_safe = (cnt_q >= ROW_LAST) && ({1'b0, cell_x} >= SAFE_LO) && ({1'b0, cell_x} < SAFE_HI);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        thr_d       = thr_q;
        lfsr_en     = 1'b0;
        o_busy      = 1'b0;
        o_ready     = 1'b0;
        wr_if.we    = 1'b0;
        wr_if.waddr = '0;
        wr_if.wdata = CELL_EMPTY;

        unique case (state_q)
            ST_IDLE: begin
                // Free-running while idle so the level depends on when it is requested
                lfsr_en = 1'b1;
            end
            ST_FILL: begin
                o_busy      = 1'b1;
                wr_if.we    = 1'b1;
                wr_if.waddr = cnt_q;
                wr_if.wdata = (!in_safe && (lfsr_v < thr_q)) ? CELL_WALL : CELL_EMPTY;
                if (wr_if.wready) begin
                    lfsr_en = 1'b1;
                    cnt_d   = cnt_q + AW'(1);
                    if (cnt_q == LAST_ADDR) state_d = ST_GOAL;
                end
            end
            ST_GOAL: begin
                o_busy      = 1'b1;
                wr_if.we    = 1'b1;
                wr_if.waddr = AW'(lfsr_v[XW-1:0]);
                wr_if.wdata = CELL_GOAL;
                if (wr_if.wready) begin
                    lfsr_en = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_ready = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A request in any state (re)starts a pass; an unfinished pass is abandoned silently
        if (i_regenerate) begin
            state_d = ST_FILL;
            cnt_d   = '0;
            thr_d   = thr_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
        end
    end

endmodule

// File: tb/tb_level_generator.sv
// Drives three generator variants (empty, saturating, full-density) in lockstep against a
// reference LFSR and a per-cell expectation derived from the density and safe-zone rules.
module tb_level_generator;
    import level_pkg::*;

    localparam int MW  = 8;
    localparam int MH  = 4;
    localparam int N   = MW * MH;
    localparam int SX0 = 2;
    localparam int SW  = 4;
    localparam int AW  = 5;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       regen  = 1'b0;
    logic       wready = 1'b1;
    logic [7:0] rating = 8'd0;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] ref_lfsr = 16'hACE1;
    int          thr_e = 0;
    int          thr_s = 0;
    int          thr_z = 0;

    logic          busy_e, rdy_e, we_e, busy_s, rdy_s, we_s, busy_z, rdy_z, we_z;
    logic [AW-1:0] addr_e, addr_s, addr_z;
    logic [1:0]    dat_e, dat_s, dat_z;

    always #5 clk = ~clk;

    level_generator_if #(.ADDR_W(AW)) if_e ();
    level_generator_if #(.ADDR_W(AW)) if_s ();
    level_generator_if #(.ADDR_W(AW)) if_z ();

    assign if_e.wready = wready;
    assign if_s.wready = wready;
    assign if_z.wready = wready;
    assign we_e = if_e.we;  assign addr_e = if_e.waddr;  assign dat_e = if_e.wdata;
    assign we_s = if_s.we;  assign addr_s = if_s.waddr;  assign dat_s = if_s.wdata;
    assign we_z = if_z.we;  assign addr_z = if_z.waddr;  assign dat_z = if_z.wdata;

    level_generator #(.MAP_W(MW), .MAP_H(MH), .SAFE_X0(SX0), .SAFE_W(SW),
                      .BASE_DENSITY(0), .DENSITY_STEP(0)) u_empty (
        .clk(clk), .rst_n(rst_n), .i_regenerate(regen), .i_rating(rating),
        .o_busy(busy_e), .o_ready(rdy_e), .wr_if(if_e));

    level_generator #(.MAP_W(MW), .MAP_H(MH), .SAFE_X0(SX0), .SAFE_W(SW),
                      .BASE_DENSITY(32), .DENSITY_STEP(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .i_regenerate(regen), .i_rating(rating),
        .o_busy(busy_s), .o_ready(rdy_s), .wr_if(if_s));

    level_generator #(.MAP_W(MW), .MAP_H(MH), .SAFE_X0(SX0), .SAFE_W(SW),
                      .BASE_DENSITY(255), .DENSITY_STEP(0), .MAX_DENSITY(255)) u_safe (
        .clk(clk), .rst_n(rst_n), .i_regenerate(regen), .i_rating(rating),
        .o_busy(busy_z), .o_ready(rdy_z), .wr_if(if_z));

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int exp_thr(input int base, input int step, input int maxd, input logic [7:0] r);
        int t;
        t = base + int'(r) * step;
        return (t > maxd) ? maxd : t;
    endfunction

    function automatic logic [1:0] exp_cell(input int addr, input logic [15:0] lf, input int thr);
        int x;
        int y;
        x = addr % MW;
        y = addr / MW;
        if (y == MH - 1 && x >= SX0 && x < SX0 + SW) return 2'b00;
        return (int'(lf[7:0]) < thr) ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_inst(input string nm, input logic busy, input logic rdy, input logic we,
                            input logic [AW-1:0] addr, input logic [1:0] dat, input int thr,
                            input bit e_we, input int e_addr, input bit e_goal, input bit e_rdy);
        chk({nm, ".busy"},  32'(busy), 32'(e_we));
        chk({nm, ".ready"}, 32'(rdy),  32'(e_rdy));
        chk({nm, ".we"},    32'(we),   32'(e_we));
        if (e_we) begin
            chk({nm, ".waddr"}, 32'(addr), 32'(e_addr));
            chk({nm, ".wdata"}, 32'(dat),  e_goal ? 32'd2 : 32'(exp_cell(e_addr, ref_lfsr, thr)));
        end
    endtask

    task automatic chk_cycle(input bit e_we, input int e_addr, input bit e_goal, input bit e_rdy);
        chk_inst("empty", busy_e, rdy_e, we_e, addr_e, dat_e, thr_e, e_we, e_addr, e_goal, e_rdy);
        chk_inst("sat",   busy_s, rdy_s, we_s, addr_s, dat_s, thr_s, e_we, e_addr, e_goal, e_rdy);
        chk_inst("safe",  busy_z, rdy_z, we_z, addr_z, dat_z, thr_z, e_we, e_addr, e_goal, e_rdy);
    endtask

    task automatic chk_reset();
        chk_cycle(1'b0, 0, 1'b0, 1'b0);
        chk("empty.rst_waddr", 32'(addr_e), 32'd0);
        chk("sat.rst_waddr",   32'(addr_s), 32'd0);
        chk("safe.rst_waddr",  32'(addr_z), 32'd0);
        chk("empty.rst_wdata", 32'(dat_e),  32'd0);
        chk("sat.rst_wdata",   32'(dat_s),  32'd0);
        chk("safe.rst_wdata",  32'(dat_z),  32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk_cycle(1'b0, 0, 1'b0, 1'b0);
            tick();
            ref_lfsr = ref_step(ref_lfsr);
        end
    endtask

    task automatic start_pass(input logic [7:0] r);
        rating = r;
        regen  = 1'b1;
        thr_e  = exp_thr(0, 0, 96, r);
        thr_s  = exp_thr(32, 16, 96, r);
        thr_z  = exp_thr(255, 0, 255, r);
        tick();
        ref_lfsr = ref_step(ref_lfsr);
        regen    = 1'b0;
        rating   = 8'($urandom);
    endtask

    // One full pass; ready must appear exactly after the goal write and nowhere earlier
    task automatic run_level(input logic [7:0] r, input int stall_at, input int stall_len,
                             input int restart_at, input logic [7:0] r2);
        int a;
        int stalled;
        bit restarted;
        a = 0;
        stalled = 0;
        restarted = 1'b0;
        start_pass(r);
        while (a < N) begin
            chk_cycle(1'b1, a, 1'b0, 1'b0);
            if (a == stall_at && stalled < stall_len) begin
                wready = 1'b0;
                stalled++;
                tick();
            end else begin
                wready = 1'b1;
                if (a == restart_at && !restarted) begin
                    restarted = 1'b1;
                    start_pass(r2);
                    a = 0;
                end else begin
                    tick();
                    ref_lfsr = ref_step(ref_lfsr);
                    a++;
                end
            end
        end
        chk_cycle(1'b1, int'(ref_lfsr) % MW, 1'b1, 1'b0);
        tick();
        ref_lfsr = ref_step(ref_lfsr);
        chk_cycle(1'b0, 0, 1'b0, 1'b1);
        tick();
        chk_cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        chk_reset();
        tick();
        tick();
        chk_reset();
        rst_n    = 1'b1;
        ref_lfsr = 16'hACE1;
        idle(10);

        // Saturated threshold, then an unsaturated random rating
        run_level(8'd255, -1, 0, -1, 8'd0);
        idle($urandom_range(1, 7));
        run_level(8'($urandom_range(0, 3)), -1, 0, -1, 8'd0);
        idle($urandom_range(1, 7));

        // Grant withheld for three cycles at address 5
        run_level(8'($urandom), 5, 3, -1, 8'd0);
        idle($urandom_range(1, 7));

        // Restart at address 10 with a different rating
        run_level(8'd1, -1, 0, 10, 8'd255);
        idle($urandom_range(1, 7));

        // Random stall position and length
        run_level(8'($urandom), $urandom_range(0, N - 1), $urandom_range(1, 4), -1, 8'd0);
        idle($urandom_range(1, 7));

        // Asynchronous reset in the middle of a fill
        start_pass(8'd3);
        for (int i = 0; i < 4; i++) begin
            chk_cycle(1'b1, i, 1'b0, 1'b0);
            tick();
            ref_lfsr = ref_step(ref_lfsr);
        end
        #2 rst_n = 1'b0;
        #1 chk_reset();
        #1 rst_n = 1'b1;
        ref_lfsr = 16'hACE1;
        tick();
        ref_lfsr = ref_step(ref_lfsr);
        idle(3);
        run_level(8'($urandom), -1, 0, -1, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
